// File: rtl/stopwatch.sv
// Free-running seconds stopwatch: divides clk to a 1-per-TICK_DIV tick, counts 00..59 in BCD,
// exports the ones digit as `color` and decodes it onto two red/blue LED pairs.
module stopwatch #(
    parameter int TICK_DIV = 125_000_000
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] color,
    output logic       red1,
    output logic       blue1,
    output logic       red2,
    output logic       blue2
);

    localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre;
    logic          tick;
    logic [3:0]    sec_ones;
    logic [2:0]    sec_tens;

    assign tick = (pre == PRE_LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // Digits advance on the same edge the prescaler wraps, so color updates with zero extra latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_ones <= 4'd0;
            sec_tens <= 3'd0;
        end else if (tick) begin
            if (sec_ones != 4'd9) begin
                sec_ones <= sec_ones + 4'd1;
            end else begin
                sec_ones <= 4'd0;
                sec_tens <= (sec_tens == 3'd5) ? 3'd0 : sec_tens + 3'd1;
            end
        end
    end

    assign color = sec_ones;
    assign red1  = color[0];
    assign blue1 = color[1];
    assign red2  = color[2];
    assign blue2 = color[3];

endmodule

// File: tb/tb_stopwatch.sv
// Self-checking bench: a seconds-since-release model checked every cycle against a
// TICK_DIV=4 stopwatch and a default-divider instance, plus hand-computed pins.
module tb_stopwatch;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] color;
    logic       red1, blue1, red2, blue2;
    logic [3:0] d_color;
    logic       d_red1, d_blue1, d_red2, d_blue2;

    int checks = 0;
    int errors = 0;
    int n = 0;   // rising edges seen since the last reset release

    stopwatch #(.TICK_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .color(color),
        .red1(red1), .blue1(blue1), .red2(red2), .blue2(blue2)
    );

    stopwatch u_dflt (
        .clk(clk), .rst(rst), .color(d_color),
        .red1(d_red1), .blue1(d_blue1), .red2(d_red2), .blue2(d_blue2)
    );

    always #4 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: elapsed whole seconds since release, modulo one minute.
    always @(posedge clk or posedge rst) begin
        if (rst) n = 0;
        else     n = n + 1;
    end

    function automatic int exp_ones();
        return ((n / DIV) % 60) % 10;
    endfunction

    function automatic int exp_tens();
        return ((n / DIV) % 60) / 10;
    endfunction

    always @(negedge clk) begin
        int ones;
        ones = rst ? 0 : exp_ones();
        check("model_color", color, ones);
        check("model_tens", dut.sec_tens, rst ? 0 : exp_tens());
        check("model_leds", {blue2, red2, blue1, red1}, ones);
        check("dflt_color", d_color, 0);
        check("dflt_leds", {d_blue2, d_red2, d_blue1, d_red1}, 0);
    end

    task automatic edges(input int k);
        repeat (k) @(negedge clk);
    endtask

    initial begin
        // Reset hold for 10 cycles.
        repeat (10) begin
            @(negedge clk);
            check("hold_color", color, 0);
            check("hold_leds", {blue2, red2, blue1, red1}, 0);
        end
        #1 rst = 1'b0;

        edges(3);
        check("pre_first_tick", color, 0);
        edges(1);
        check("first_tick", color, 1);
        edges(4);
        check("second_tick", color, 2);
        edges(12);                       // 20 edges: 5 s
        check("color5", color, 5);
        check("c5_red1", red1, 1);
        check("c5_blue1", blue1, 0);
        check("c5_red2", red2, 1);
        check("c5_blue2", blue2, 0);
        edges(16);                       // 36 edges: 9 s
        check("color9", color, 9);
        check("c9_red1", red1, 1);
        check("c9_blue1", blue1, 0);
        check("c9_red2", red2, 0);
        check("c9_blue2", blue2, 1);
        edges(4);                        // 40 edges: 10 s
        check("digit_wrap_ones", color, 0);
        check("digit_wrap_tens", dut.sec_tens, 1);
        edges(196);                      // 236 edges: 59 s
        check("s59_ones", color, 9);
        check("s59_tens", dut.sec_tens, 5);
        edges(4);                        // 240 edges: minute wrap
        check("minute_wrap_ones", color, 0);
        check("minute_wrap_tens", dut.sec_tens, 0);
        edges(4);
        check("after_wrap", color, 1);
        edges(4);
        check("after_wrap2", color, 2);

        // Mid-count reset at color 7, pre 2 (30 edges after a fresh release).
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
        edges(30);
        check("mid_color7", color, 7);
        check("mid_pre2", dut.pre, 2);
        #1 rst = 1'b1;
        #1;
        check("async_color", color, 0);
        check("async_leds", {blue2, red2, blue1, red1}, 0);
        @(negedge clk);
        #1 rst = 1'b0;
        edges(3);
        check("mid_restart_hold", color, 0);
        edges(1);
        check("mid_restart_tick", color, 1);

        // Random run lengths and asynchronous reset pulses; the compare process checks each cycle.
        for (int i = 0; i < 10; i++) begin
            edges($urandom_range(5, 400));
            #($urandom_range(1, 3)) rst = 1'b1;
            #1;
            check("rand_async_color", color, 0);
            edges($urandom_range(1, 3));
            #1 rst = 1'b0;
        end
        edges(300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
